// File: rtl/cpu_pkg.sv
// Shared command encoding and sequencer state definitions for the command
// sequencer slice.
package cpu_pkg;

  localparam int SUB_W    = 2;
  localparam int MODE_W   = 1;
  localparam int OPC_W    = 4;
  localparam int CMD_W    = OPC_W + MODE_W + SUB_W;
  localparam int MODE_POS = SUB_W;
  localparam int OPC_LSB  = SUB_W + MODE_W;

  // Datapath no-operation: opcode 0, mode bit set, sub-op 0.
  localparam logic [CMD_W-1:0] NOP = 7'b0000100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_HALT
  } seq_state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [CMD_W-1:0] cmd);
    return cmd[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic mode_of(input logic [CMD_W-1:0] cmd);
    return cmd[MODE_POS];
  endfunction

endpackage

// File: rtl/cmd_sequencer_if.sv
// Host command queue, datapath link and result port of the command sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// valid never waits on ready, and in_ready does not depend on in_valid.
interface cmd_sequencer_if #(
  parameter int N     = 8,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [6:0]               in_cmd;
  logic [N-1:0]             in_d1;
  logic [N-1:0]             in_d2;
  logic [N-1:0]             in_d3;
  logic [6:0]               cmdout;
  logic [N-1:0]             dout_1;
  logic [N-1:0]             dout_2;
  logic [N-1:0]             dout_3;
  logic [N-1:0]             dp_low;
  logic [N-1:0]             dp_high;
  logic                     dp_zero;
  logic                     dp_error;
  logic                     res_valid;
  logic                     res_ready;
  logic [N-1:0]             res_low;
  logic [N-1:0]             res_high;
  logic                     res_zero;
  logic                     res_error;
  logic                     halt;
  logic                     clear_halt;
  logic [$clog2(DEPTH):0]   count;
  cpu_pkg::seq_state_t      dbg_state;

  modport slave (
    input  in_valid, in_cmd, in_d1, in_d2, in_d3,
    input  dp_low, dp_high, dp_zero, dp_error,
    input  res_ready, clear_halt,
    output in_ready, cmdout, dout_1, dout_2, dout_3,
    output res_valid, res_low, res_high, res_zero, res_error,
    output halt, count, dbg_state
  );

  modport master (
    output in_valid, in_cmd, in_d1, in_d2, in_d3,
    output dp_low, dp_high, dp_zero, dp_error,
    output res_ready, clear_halt,
    input  in_ready, cmdout, dout_1, dout_2, dout_3,
    input  res_valid, res_low, res_high, res_zero, res_error,
    input  halt, count, dbg_state
  );
endinterface

// File: rtl/cmd_fifo.sv
// Circular command queue; pushes are dropped when full, pops when empty.
module cmd_fifo #(
  parameter int W     = 31,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Queues host commands and issues them one at a time to a fixed-latency
// datapath, capturing each result and stopping on a datapath error.
module cmd_sequencer
  import cpu_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input logic            clk,
  input logic            rst,
  cmd_sequencer_if.slave sif
);
  localparam int FW = CMD_W + 3*N;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(LAT - 1);

  seq_state_t state, state_nxt;

  logic [FW-1:0]          head;
  logic [CMD_W-1:0]       head_cmd;
  logic [N-1:0]           head_d1, head_d2, head_d3;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   full, empty, push, pop, res_write;
  logic [N-1:0]           d1_q, d2_q, d3_q;
  logic [CW-1:0]          wait_cnt;
  logic                   res_valid_q, res_zero_q, res_error_q;
  logic [N-1:0]           res_low_q, res_high_q;

  assign push = sif.in_valid && !full;
  assign {head_cmd, head_d1, head_d2, head_d3} = head;

  cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({sif.in_cmd, sif.in_d1, sif.in_d2, sif.in_d3}),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    res_write = 1'b0;
    case (state)
      S_IDLE:    if (!empty) state_nxt = S_ISSUE;
      S_ISSUE: begin
        pop       = 1'b1;
        state_nxt = S_WAIT;
      end
      // The result slot must be free (or freeing) before the write.
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST && (!res_valid_q || sif.res_ready)) begin
          res_write = 1'b1;
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (res_error_q)  state_nxt = S_HALT;
        else if (!empty)  state_nxt = S_ISSUE;
        else              state_nxt = S_IDLE;
      end
      S_HALT:    if (sif.clear_halt) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      d3_q     <= '0;
    end else begin
      if (state != S_WAIT)          wait_cnt <= '0;
      else if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 1'b1;
      if (state == S_ISSUE) begin
        d1_q <= head_d1;
        d2_q <= head_d2;
        d3_q <= head_d3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_q <= 1'b0;
      res_low_q   <= '0;
      res_high_q  <= '0;
      res_zero_q  <= 1'b0;
      res_error_q <= 1'b0;
    end else begin
      if (res_write) begin
        res_valid_q <= 1'b1;
        res_low_q   <= sif.dp_low;
        res_high_q  <= sif.dp_high;
        res_zero_q  <= sif.dp_zero;
        res_error_q <= sif.dp_error;
      end else if (res_valid_q && sif.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // Operands follow the head only while issuing; otherwise they hold.
  assign sif.cmdout    = (state == S_ISSUE) ? head_cmd : NOP;
  assign sif.dout_1    = (state == S_ISSUE) ? head_d1  : d1_q;
  assign sif.dout_2    = (state == S_ISSUE) ? head_d2  : d2_q;
  assign sif.dout_3    = (state == S_ISSUE) ? head_d3  : d3_q;
  assign sif.in_ready  = !full;
  assign sif.count     = fifo_count;
  assign sif.halt      = (state == S_HALT);
  assign sif.dbg_state = state;
  assign sif.res_valid = res_valid_q;
  assign sif.res_low   = res_low_q;
  assign sif.res_high  = res_high_q;
  assign sif.res_zero  = res_zero_q;
  assign sif.res_error = res_error_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer with a one-cycle datapath model, an issue
// scoreboard and a result scoreboard.
module tb_cmd_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [30:0] exp_q[$];
  logic [17:0] res_q[$];

  typedef struct {
    logic [6:0] cmd;
    logic [7:0] d1, d2, d3;
    logic [7:0] low, high;
    logic       zero, err;
  } vec_t;
  vec_t vt[8];

  cmd_sequencer_if #(.N(8), .DEPTH(4)) sif ();

  cmd_sequencer #(.N(8), .DEPTH(4), .LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- datapath model ----------------
  // Returns {error, zero, high, low}.
  function automatic logic [17:0] model(input logic [6:0] cmd,
                                        input logic [7:0] a, b, c);
    logic [15:0] s;
    logic [7:0]  lo, hi;
    logic        er;
    er = 1'b0;
    lo = 8'h00;
    hi = 8'h00;
    case (opcode_of(cmd))
      4'b0001: begin
        s  = {{8{a[7]}}, a} + {{8{b[7]}}, b};
        lo = s[7:0];
        hi = s[15:8];
      end
      4'b1110: begin
        if (b == 8'h00) er = 1'b1;
        else begin
          lo = 8'($signed(a) / $signed(b));
          hi = 8'($signed(a) % $signed(b));
        end
      end
      4'b1010: lo = a & b;
      default: begin
        lo = a ^ b;
        hi = c;
      end
    endcase
    return {er, (!er && {hi, lo} == 16'h0000), hi, lo};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sif.dp_low   <= '0;
      sif.dp_high  <= '0;
      sif.dp_zero  <= 1'b0;
      sif.dp_error <= 1'b0;
    end else if (sif.cmdout != NOP) begin
      {sif.dp_error, sif.dp_zero, sif.dp_high, sif.dp_low} <=
        model(sif.cmdout, sif.dout_1, sif.dout_2, sif.dout_3);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) begin
    if (rst && sif.in_valid && sif.in_ready) begin
      exp_q.push_back({sif.in_cmd, sif.in_d1, sif.in_d2, sif.in_d3});
      res_q.push_back(model(sif.in_cmd, sif.in_d1, sif.in_d2, sif.in_d3));
    end
  end

  always @(negedge clk) begin
    if (rst && sif.cmdout != NOP) begin
      if (exp_q.size() == 0) fail("issue_unexpected");
      else check("issue_order", {sif.cmdout, sif.dout_1, sif.dout_2, sif.dout_3}, exp_q.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rst && sif.res_valid && sif.res_ready) begin
      if (res_q.size() == 0) fail("result_unexpected");
      else check("result_sb", {sif.res_error, sif.res_zero, sif.res_high, sif.res_low}, res_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [6:0] c, input logic [7:0] a, b, d);
    int t;
    t = 0;
    sif.in_valid = 1'b1;
    sif.in_cmd   = c;
    sif.in_d1    = a;
    sif.in_d2    = b;
    sif.in_d3    = d;
    while (!sif.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail("push_timeout");
    @(negedge clk);
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_res();
    int t;
    t = 0;
    while (!sif.res_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30) fail("result_timeout");
  endtask

  task automatic consume();
    sif.res_ready = 1'b1;
    @(negedge clk);
    sif.res_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    sif.clear_halt = 1'b1;
    @(negedge clk);
    sif.clear_halt = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vt[0] = '{7'b0001000, 8'd10,  8'd3,   8'h00, 8'd13, 8'h00, 1'b0, 1'b0};
    vt[1] = '{7'b0001000, 8'hFB,  8'd3,   8'h00, 8'hFE, 8'hFF, 1'b0, 1'b0};
    vt[2] = '{7'b0001101, 8'd127, 8'd1,   8'h00, 8'h80, 8'h00, 1'b0, 1'b0};
    vt[3] = '{7'b1010001, 8'h0F,  8'hF0,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[4] = '{7'b1110011, 8'd100, 8'd7,   8'h00, 8'd14, 8'd2,  1'b0, 1'b0};
    vt[5] = '{7'b1110011, 8'd50,  8'd0,   8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[6] = '{7'b0001000, 8'd0,   8'd0,   8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[7] = '{7'b0110000, 8'h3C,  8'h0F,  8'h55, 8'h33, 8'h55, 1'b0, 1'b0};

    sif.in_valid   = 1'b0;
    sif.in_cmd     = '0;
    sif.in_d1      = '0;
    sif.in_d2      = '0;
    sif.in_d3      = '0;
    sif.res_ready  = 1'b0;
    sif.clear_halt = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  sif.in_ready,  1);
    check("rst_count",     sif.count,     0);
    check("rst_cmdout",    sif.cmdout,    NOP);
    check("rst_dout",      {sif.dout_1, sif.dout_2, sif.dout_3}, 0);
    check("rst_res_valid", sif.res_valid, 0);
    check("rst_res",       {sif.res_error, sif.res_zero, sif.res_high, sif.res_low}, 0);
    check("rst_halt",      sif.halt,      0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", sif.in_ready, 1);
    check("post_rst_state",    sif.dbg_state, S_IDLE);

    // Table of single commands, each taken through to its result
    for (int i = 0; i < 8; i++) begin
      push_cmd(vt[i].cmd, vt[i].d1, vt[i].d2, vt[i].d3);
      wait_res();
      check("vec_res_low",   sif.res_low,   vt[i].low);
      check("vec_res_high",  sif.res_high,  vt[i].high);
      check("vec_res_zero",  sif.res_zero,  vt[i].zero);
      check("vec_res_error", sif.res_error, vt[i].err);
      check("vec_cmdout_capture", sif.cmdout, NOP);
      @(negedge clk);
      check("vec_halt",   sif.halt,   vt[i].err);
      check("vec_cmdout", sif.cmdout, NOP);
      consume();
      check("vec_res_valid_clear", sif.res_valid, 0);
      if (vt[i].err) begin
        pulse_clear();
        check("vec_halt_released", sif.halt, 0);
      end
    end

    // Error halts issue until clear_halt; queue keeps accepting
    push_cmd(7'b1110011, 8'd50, 8'd0, 8'h00);
    push_cmd(7'b0001000, 8'd2,  8'd2, 8'h00);
    wait_res();
    check("halt_res_error", sif.res_error, 1);
    @(negedge clk);
    check("halt_set", sif.halt, 1);
    for (int i = 0; i < 4; i++) begin
      check("halt_cmdout", sif.cmdout, NOP);
      check("halt_count",  sif.count,  1);
      @(negedge clk);
    end
    push_cmd(7'b0001000, 8'd5, 8'd6, 8'h00);
    check("halt_push_count", sif.count, 2);
    consume();
    check("halt_still", sif.halt, 1);
    pulse_clear();
    check("halt_cleared", sif.halt, 0);
    wait_res();
    check("after_clear_res1", sif.res_low, 8'd4);
    consume();
    wait_res();
    check("after_clear_res2", sif.res_low, 8'd11);
    consume();

    // Back-pressure: result slot held, queue fills, fifth push waits for a pop
    push_cmd(7'b0001000, 8'd1, 8'd2, 8'h00);
    push_cmd(7'b0001000, 8'd3, 8'd4, 8'h00);
    repeat (8) @(negedge clk);
    check("bp_res_valid", sif.res_valid, 1);
    check("bp_res_low",   sif.res_low,   8'd3);
    check("bp_state",     sif.dbg_state, S_WAIT);
    check("bp_count0",    sif.count,     0);
    for (int i = 0; i < 4; i++) push_cmd(7'b0001000, 8'(10 + i), 8'd1, 8'h00);
    check("bp_count_full", sif.count,    4);
    check("bp_in_ready",   sif.in_ready, 0);
    sif.in_valid = 1'b1;
    sif.in_cmd   = 7'b0001000;
    sif.in_d1    = 8'd20;
    sif.in_d2    = 8'd20;
    sif.in_d3    = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall_ready",  sif.in_ready, 0);
      check("bp_stall_count",  sif.count,    4);
      check("bp_stall_cmdout", sif.cmdout,   NOP);
      check("bp_stall_res",    sif.res_low,  8'd3);
    end
    sif.res_ready = 1'b1;
    begin
      int t;
      t = 0;
      while (!sif.in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) fail("bp_fifth_timeout");
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
    begin
      int t;
      t = 0;
      while (!(sif.count == 0 && sif.dbg_state == S_IDLE && !sif.res_valid) && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) fail("bp_drain_timeout");
    end
    sif.res_ready = 1'b0;
    check("bp_issue_q_empty",  exp_q.size(), 0);
    check("bp_result_q_empty", res_q.size(), 0);

    // Reset during WAIT with two entries queued
    push_cmd(7'b0001000, 8'd1, 8'd1, 8'h00);
    wait_res();
    push_cmd(7'b0001000, 8'd2, 8'd1, 8'h00);
    push_cmd(7'b0001000, 8'd3, 8'd1, 8'h00);
    push_cmd(7'b0001000, 8'd4, 8'd1, 8'h00);
    repeat (3) @(negedge clk);
    check("mid_state_wait", sif.dbg_state, S_WAIT);
    check("mid_count",      sif.count,     2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cmdout",    sif.cmdout,    NOP);
    check("mid_rst_count",     sif.count,     0);
    check("mid_rst_res_valid", sif.res_valid, 0);
    check("mid_rst_in_ready",  sif.in_ready,  1);
    check("mid_rst_dout",      sif.dout_1,    0);
    exp_q.delete();
    res_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_mid_cmdout",    sif.cmdout,    NOP);
      check("post_mid_res_valid", sif.res_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameter: N, 8, datapath operand/result width.
REQ-002 Parameter: DEPTH, 4, command queue depth in entries (power of 2, >=2).
REQ-003 Parameter: LAT, 1, datapath cycles from command issue to valid result (>=1).
REQ-004 Port: clk  in  1  single clock, rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: in_valid  in  1  host command valid.
REQ-007 Port: in_ready  out  1  queue can accept a command.
REQ-008 Port: in_cmd  in  7  command: [6:3] opcode, [2] mode, [1:0] sub-op.
REQ-009 Port: in_d1, in_d2, in_d3  in  N each  signed operands bundled with the command.
REQ-010 Port: cmdout  out  7  command to datapath cmdin.
REQ-011 Port: dout_1, dout_2, dout_3  out  N each  operands to datapath din_1..din_3.
REQ-012 Port: dp_low, dp_high  in  N each  datapath result halves.
REQ-013 Port: dp_zero, dp_error  in  1 each  datapath flags.
REQ-014 Port: res_valid  out  1  captured result available.
REQ-015 Port: res_ready  in  1  host consumes result.
REQ-016 Port: res_low, res_high  out  N each; res_zero, res_error  out  1 each  captured result.
REQ-017 Port: halt  out  1  sequencer stopped on datapath error.
REQ-018 Port: clear_halt  in  1  host releases halt.
REQ-019 Port: count  out  $clog2(DEPTH)+1  queued entries.

Function
REQ-020 Push: in_valid && in_ready stores {in_cmd, in_d1..3} in FIFO order; in_ready = (count < DEPTH), independent of pop in same cycle.
REQ-021 Simultaneous push and pop: count unchanged, both take effect; pointers wrap modulo DEPTH.
REQ-022 FSM states: IDLE, ISSUE, WAIT, CAPTURE, HALT.
REQ-023 IDLE: cmdout = NOP (7'b0000100); if queue non-empty -> ISSUE next cycle.
REQ-024 ISSUE: exactly one cycle; cmdout and dout_1..3 = head entry; head popped at the end of this cycle; -> WAIT.
REQ-025 WAIT: cmdout = NOP, dout_* hold last values; lasts LAT cycles; the dp_* values sampled on the last WAIT cycle are written to res_* -> CAPTURE.
REQ-026 Result write requires res_valid=0 or res_ready=1 that cycle; otherwise WAIT extends (NOP held) until the slot frees.
REQ-027 CAPTURE: res_valid=1 from this cycle; if captured res_error=1 -> HALT, else if queue non-empty -> ISSUE, else -> IDLE.
REQ-028 res_valid clears the cycle after res_valid && res_ready unless a new result is written that same cycle.
REQ-029 HALT: halt=1, cmdout = NOP, no issue; queue still accepts pushes; clear_halt=1 -> IDLE next cycle, queue preserved.
REQ-030 clear_halt outside HALT has no effect.
REQ-031 Commands are passed through unmodified; memory and NOP commands are sequenced like any other.

Reset
REQ-032 rst=0 asynchronously: state IDLE, queue empty, count=0, cmdout=NOP, dout_*=0, res_*=0, res_valid=0, halt=0.
REQ-033 in_ready=1 during and after reset; reset mid-operation discards queued and in-flight commands; no result is produced for them.

Structure
REQ-034 Shared package cpu_pkg holds: NOP constant, command field widths/positions, FSM state enum.
REQ-035 One sub-module cmd_fifo (parameterised width/DEPTH, push/pop/count/full/empty); FSM and result register live in cmd_sequencer.

Verification
REQ-036 Push add 7'b0001000, d1=10, d2=3, datapath model LAT=1 -> cmdout=0001000 for one cycle, then NOP; res_low=13, res_high=0, res_valid=1.
REQ-037 Push DEPTH+1=5 commands back to back while idle-blocked by res_ready=0 -> in_ready=0 at count=4, fifth accepted only after a pop; commands issued in push order.
REQ-038 Division by zero 7'b1110011, d2=0 with model dp_error=1 -> res_error=1, halt=1, cmdout=NOP; a queued command is not issued until clear_halt pulse, then issued.
REQ-039 res_ready=0 with two queued commands -> second result waits in WAIT with cmdout=NOP; first result stays stable until res_ready=1.
REQ-040 rst=0 asserted during WAIT with 2 entries queued -> cmdout=NOP, count=0, res_valid=0 immediately; no further issues after rst=1.
REQ-041 Zero-result op 7'b1010001, model dp_zero=1, dp_low=0 -> res_zero=1, res_error=0, halt=0.
